// File: rtl/ahblite_dma_master.sv
// ahblite_dma_master: single-channel AHB-Lite word-copy initiator, one read then one write per word.
// Optional AHB_DMA_IRQ_EN adds a sticky irq output with irq_clr.
module ahblite_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef AHB_DMA_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic unused_bits;
  assign unused_bits = ^{src_addr[1:0], dst_addr[1:0]};
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        src_d   = {src_addr[31:2], 2'b00};
        dst_d   = {dst_addr[31:2], 2'b00};
        cnt_d   = len;
        err_d   = 1'b0;
        state_d = (len != '0) ? RADDR : DONE;
      end
      RADDR: state_d = HREADY ? RDATA : RADDR;
      RDATA: if (HRESP) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = DONE;
      end else if (HREADY) begin
        buf_d   = HRDATA;
        src_d   = src_q + 32'd4;
        state_d = WADDR;
      end
      WADDR: state_d = HREADY ? WDATA : WADDR;
      WDATA: if (HRESP) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = DONE;
      end else if (HREADY) begin
        dst_d   = dst_q + 32'd4;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : RADDR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // Address-phase signals are decoded from state so they hold steady through HREADY stalls.
  assign HADDR     = (state_q == RADDR) ? src_q : (state_q == WADDR) ? dst_q : 32'h0;
  assign HTRANS    = (state_q == RADDR || state_q == WADDR) ? 2'b10 : 2'b00;
  assign HWRITE    = (state_q == WADDR);
  assign HWDATA    = buf_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
`ifdef AHB_DMA_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = (state_q == DONE) | (irq_q & ~irq_clr);
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_ahblite_dma_master.sv
// tb_ahblite_dma_master: directed vector bench with an AHB-Lite responder model and bus monitor.
module tb_ahblite_dma_master;
  logic clk, RSTn, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic busy, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic HMASTLOCK, HWRITE, HREADY, HRESP;
`ifdef AHB_DMA_IRQ_EN
  logic irq;
  logic irq_clr;
  initial irq_clr = 1'b0;
`endif

  ahblite_dma_master #(.LEN_W(16)) dut (
    .clk(clk), .RSTn(RSTn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
`ifdef AHB_DMA_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h2000_0000: memf = 32'h0000_00A1;
      32'h2000_0004: memf = 32'h0000_00B2;
      32'h2000_0008: memf = 32'h0000_00C3;
      default:       memf = ~a;
    endcase
  endfunction

  // Responder: wt wait states per phase; a read at eaddr gets a two-cycle ERROR.
  int wt = 0;
  bit eon = 0;
  logic [31:0] eaddr = 32'h0;
  logic sdp_v, sdp_w, serr;
  logic [31:0] sdp_a;
  int ph;
  always_comb begin
    serr   = sdp_v && !sdp_w && eon && (sdp_a == eaddr);
    HRESP  = serr;
    HREADY = serr ? (ph == 1) : (sdp_v || HTRANS == 2'b10) ? (ph >= wt) : 1'b1;
    HRDATA = (sdp_v && !sdp_w) ? memf(sdp_a) : 32'h0;
  end
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sdp_v <= 1'b0;
      sdp_w <= 1'b0;
      sdp_a <= 32'h0;
      ph    <= 0;
    end else if (HREADY) begin
      sdp_v <= (HTRANS == 2'b10);
      sdp_w <= HWRITE;
      sdp_a <= HADDR;
      ph    <= 0;
    end else ph <= ph + 1;
  end

  logic [31:0] rd_log[$], wa_log[$], wd_log[$];
  int ns_n = 0, done_n = 0, busy_n = 0;
  bit p_astall = 0, p_wstall = 0, p_wr = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  always @(negedge clk) begin
    busy_n += int'(busy);
    if (done) done_n++;
    if (HREADY && sdp_v && !HRESP) begin
      if (sdp_w) begin
        wa_log.push_back(sdp_a);
        wd_log.push_back(HWDATA);
      end else rd_log.push_back(sdp_a);
    end
    if (HREADY && HTRANS == 2'b10) ns_n++;
    if (p_astall) begin
      chk("stall_htrans", {30'h0, HTRANS}, 32'h2);
      chk("stall_haddr", HADDR, p_addr);
      chk("stall_hwrite", {31'h0, HWRITE}, {31'h0, p_wr});
    end
    if (p_wstall && sdp_v) chk("stall_hwdata", HWDATA, p_wdata);
    p_astall = (HTRANS == 2'b10) && !HREADY;
    p_addr   = HADDR;
    p_wr     = HWRITE;
    p_wstall = sdp_v && sdp_w && !HREADY;
    p_wdata  = HWDATA;
  end

  typedef struct {
    logic [31:0] src, dst;
    logic [15:0] len;
    int wt;
    bit eon;
    logic [31:0] eaddr;
    bit poke;
    int done_c;
    bit err;
    int nrd, nwr, nns;
  } vec_t;
  vec_t vt[7];

  task automatic run(input vec_t v);
    int k, rb, wb, nb, db, bb;
    logic [31:0] sa, da;
    sa = {v.src[31:2], 2'b00};
    da = {v.dst[31:2], 2'b00};
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len;
    wt = v.wt; eon = v.eon; eaddr = v.eaddr; start = 1'b1;
    rb = rd_log.size(); wb = wa_log.size(); nb = ns_n; db = done_n; bb = busy_n;
    @(posedge clk);
    @(negedge clk);
    if (v.poke) begin
      src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; len = 16'd7;
    end else start = 1'b0;
    chk("err_cleared", {31'h0, err}, 32'h0);
    k = 1;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k >= 300) chk("done_timeout", 32'(k), 32'(v.done_c));
    chk("done_cycle", 32'(k), 32'(v.done_c));
    chk("err_at_done", {31'h0, err}, {31'h0, v.err});
    @(negedge clk);
    chk("busy_after", {31'h0, busy}, 32'h0);
    chk("done_single", {31'h0, done}, 32'h0);
    chk("err_sticky", {31'h0, err}, {31'h0, v.err});
    chk("done_pulses", 32'(done_n - db), 32'h1);
    chk("busy_cycles", 32'(busy_n - bb), 32'(v.done_c));
    chk("reads", 32'(rd_log.size() - rb), 32'(v.nrd));
    chk("writes", 32'(wa_log.size() - wb), 32'(v.nwr));
    chk("nonseq", 32'(ns_n - nb), 32'(v.nns));
    for (int i = 0; i < v.nrd && rb + i < rd_log.size(); i++)
      chk("read_addr", rd_log[rb + i], sa + 32'(4 * i));
    for (int i = 0; i < v.nwr && wb + i < wa_log.size(); i++) begin
      chk("write_addr", wa_log[wb + i], da + 32'(4 * i));
      chk("write_data", wd_log[wb + i], memf(sa + 32'(4 * i)));
    end
  endtask

  initial begin
    int db;
    vt[0] = '{32'h2000_0000, 32'h2000_0100, 16'd3, 0, 1'b0, 32'h0, 1'b0, 13, 1'b0, 3, 3, 6};
    vt[1] = '{32'h3000_0010, 32'h4000_0020, 16'd1, 2, 1'b0, 32'h0, 1'b0, 13, 1'b0, 1, 1, 2};
    vt[2] = '{32'h2000_0000, 32'h2000_0100, 16'd0, 0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 0, 0, 0};
    vt[3] = '{32'h1000_0000, 32'h1000_1000, 16'd4, 0, 1'b1, 32'h1000_0004, 1'b0, 7, 1'b1, 1, 1, 3};
    vt[4] = '{32'hFFFF_FFFE, 32'h0000_0040, 16'd2, 0, 1'b0, 32'h0, 1'b0, 9, 1'b0, 2, 2, 4};
    vt[5] = '{32'h5000_0001, 32'h5000_0003, 16'd2, 1, 1'b0, 32'h0, 1'b0, 17, 1'b0, 2, 2, 4};
    vt[6] = '{32'h6000_0000, 32'h6000_0100, 16'd2, 0, 1'b0, 32'h0, 1'b1, 9, 1'b0, 2, 2, 4};
    RSTn = 1'b0; start = 1'b0; src_addr = 0; dst_addr = 0; len = 0;
    @(negedge clk);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("hsize", {29'h0, HSIZE}, 32'h2);
    chk("hburst", {29'h0, HBURST}, 32'h0);
    chk("hprot", {28'h0, HPROT}, 32'h3);
    chk("hmastlock", {31'h0, HMASTLOCK}, 32'h0);
    RSTn = 1'b1;
    for (int i = 0; i < 7; i++) run(vt[i]);
    // Asynchronous reset while the first word sits in its write data phase.
    @(negedge clk);
    src_addr = 32'h7000_0000; dst_addr = 32'h7000_0100; len = 16'd2; wt = 0; eon = 0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_hwdata", HWDATA, 32'h8FFF_FFFF);
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    #2 RSTn = 1'b0;
    #1;
    chk("async_busy", {31'h0, busy}, 32'h0);
    chk("async_done", {31'h0, done}, 32'h0);
    chk("async_err", {31'h0, err}, 32'h0);
    chk("async_haddr", HADDR, 32'h0);
    chk("async_htrans", {30'h0, HTRANS}, 32'h0);
    chk("async_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("async_hwdata", HWDATA, 32'h0);
    db = done_n;
    @(negedge clk);
    RSTn = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", 32'(done_n - db), 32'h0);
    chk("idle_after_reset", {31'h0, busy}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
